// File: rtl/multdiv_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit. This file holds the FSM
// encodings, the op-select values and the width of the iteration counter.
package multdiv_iter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // The counter must hold the values 0..N.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/multdiv_iter_if.sv
// Start/operand/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_iter_if #(
   parameter int N = 32
);

   logic         ctrl_mult;
   logic         ctrl_div;
   logic [N-1:0] operand_a;
   logic [N-1:0] operand_b;
   logic [N-1:0] result;
   logic         result_rdy;
   logic         exception;
   logic         busy;

   modport master (
      output ctrl_mult, ctrl_div, operand_a, operand_b,
      input  result, result_rdy, exception, busy
   );

   modport slave (
      input  ctrl_mult, ctrl_div, operand_a, operand_b,
      output result, result_rdy, exception, busy
   );

endinterface

// File: rtl/multdiv_iter_addsub.sv
// Adder/subtractor of width W. The carry out is 1 on a subtract when a >= b (unsigned),
// so the divide step uses it as its "no borrow" flag.
module addsub_Nbit #(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] b_eff;

   assign b_eff       = b ^ {W{sub}};
   assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed N-bit multiply/divide unit. It runs shift-add multiply or restoring divide
// on operand magnitudes and applies the sign at the result edge, N+1 cycles after start.
module multdiv_iter
   import multdiv_iter_pkg::*;
#(
   parameter int N = 32
) (
   input logic           clk,
   input logic           clr_n,
   multdiv_iter_if.slave bus
);

   localparam int CW = cnt_width(N);

   logic [1:0]    state;
   logic          op;
   logic [CW-1:0] cnt;
   logic          sign_a;
   logic          sign_b;
   logic          div_zero;
   logic [N-1:0]  opnd;
   logic [N-1:0]  hi;
   logic [N-1:0]  mq;
   logic [N-1:0]  result_q;
   logic          rdy_q;
   logic          exc_q;

   logic         start;
   logic         start_op;
   logic [N-1:0] abs_a;
   logic [N-1:0] abs_b;

   assign start    = bus.ctrl_mult | bus.ctrl_div;
   assign start_op = bus.ctrl_mult ? OP_MULT : OP_DIV;
   assign abs_a    = bus.operand_a[N-1] ? -bus.operand_a : bus.operand_a;
   assign abs_b    = bus.operand_b[N-1] ? -bus.operand_b : bus.operand_b;

   // The shared adder either accumulates the multiplicand or trial-subtracts the divisor.
   logic [N:0]   add_a;
   logic [N:0]   add_b;
   logic [N:0]   add_sum;
   logic         add_sub;
   logic         add_cout;
   logic [N-1:0] hi_nxt;
   logic [N-1:0] mq_nxt;

   always_comb begin
      // NOTE: every output gets a default first, so no path through the block infers a latch.
      add_a   = {1'b0, hi};
      add_b   = '0;
      add_sub = 1'b0;
      if (op == OP_MULT) begin
         if (mq[0]) add_b = {1'b0, opnd};
      end else begin
         add_a   = {hi, mq[N-1]};
         add_b   = {1'b0, opnd};
         add_sub = 1'b1;
      end
   end

   addsub_Nbit #(.W(N + 1)) u_addsub (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      hi_nxt = add_sum[N:1];
      mq_nxt = {add_sum[0], mq[N-1:1]};
      if (op == OP_DIV) begin
         hi_nxt = add_cout ? add_sum[N-1:0] : add_a[N-1:0];
         mq_nxt = {mq[N-2:0], add_cout};
      end
   end

   // Sign correction and exception detection for the result edge.
   logic           neg;
   logic [2*N-1:0] prod_s;
   logic [N:0]     prod_top;
   logic [N-1:0]   quo_s;
   logic [N-1:0]   fin_res;
   logic           fin_exc;

   assign neg      = sign_a ^ sign_b;
   assign prod_s   = neg ? -{hi, mq} : {hi, mq};
   assign prod_top = prod_s[2*N-1:N-1];
   assign quo_s    = neg ? -mq : mq;

   always_comb begin
      fin_res = prod_s[N-1:0];
      fin_exc = !((&prod_top) || !(|prod_top));
      if (op == OP_DIV) begin
         if (div_zero) begin
            fin_res = '0;
            fin_exc = 1'b1;
         end else begin
            fin_res = quo_s;
            fin_exc = !neg && mq[N-1];
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= ST_IDLE;
         op       <= OP_MULT;
         cnt      <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         opnd     <= '0;
         hi       <= '0;
         mq       <= '0;
         result_q <= '0;
         rdy_q    <= 1'b0;
         exc_q    <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments only, so every reader sees pre-edge values.
         rdy_q <= 1'b0;
         if (start) begin
            state    <= ST_RUN;
            op       <= start_op;
            cnt      <= '0;
            sign_a   <= bus.operand_a[N-1];
            sign_b   <= bus.operand_b[N-1];
            div_zero <= (bus.operand_b == '0);
            hi       <= '0;
            opnd     <= (start_op == OP_MULT) ? abs_a : abs_b;
            mq       <= (start_op == OP_MULT) ? abs_b : abs_a;
            result_q <= '0;
            exc_q    <= 1'b0;
         end else begin
            case (state)
               ST_RUN: begin
                  hi  <= hi_nxt;
                  mq  <= mq_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(N - 1)) state <= ST_DONE;
               end
               ST_DONE: begin
                  result_q <= fin_res;
                  exc_q    <= fin_exc;
                  rdy_q    <= 1'b1;
                  state    <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.result     = result_q;
   assign bus.result_rdy = rdy_q;
   assign bus.exception  = exc_q;
   assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter. It applies a table of directed vectors, randomized operations
// scored against an arithmetic model, and restart/reset sequences.
module tb_multdiv_iter;

   localparam int N   = 32;
   localparam int LAT = N + 1;

   logic clk = 1'b0;
   logic clr_n;
   int   total = 0;
   int   bad   = 0;

   multdiv_iter_if #(.N(N)) bus ();

   multdiv_iter #(.N(N)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         mult;
      logic         div;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] res;
      logic         exc;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Reference: exact signed arithmetic in 64 bits; exception when the value does not fit N bits.
   function automatic void model(input logic m, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] r, output logic e);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!m && b == '0) begin
         r = '0;
         e = 1'b1;
      end else begin
         p = m ? sa * sb : sa / sb;
         r = p[N-1:0];
         e = (p != longint'($signed(r)));
      end
   endfunction

   function automatic logic [N-1:0] rand_operand();
      logic [N-1:0] corner [5];
      logic [N-1:0] v;
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      case ($urandom_range(0, 3))
         0: v = corner[$urandom_range(0, 4)];
         1: v = N'($urandom_range(0, 40)) - N'(20);
         2: v = $urandom >> $urandom_range(0, 31);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Start on the next rising edge and wait (bounded) for result_rdy.
   task automatic run_op(input logic m, input logic d, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int lat, output logic [N-1:0] res, output logic exc,
                         output logic busy_ok, output logic clr_ok);
      @(negedge clk);
      bus.ctrl_mult = m;
      bus.ctrl_div  = d;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      bus.operand_a = $urandom;
      bus.operand_b = $urandom;
      busy_ok = bus.busy;
      clr_ok  = (bus.result == '0) && !bus.exception && !bus.result_rdy;
      lat = -1;
      for (int k = 1; k <= LAT + 8; k++) begin
         @(posedge clk);
         #1;
         if (bus.result_rdy) begin
            lat     = k;
            busy_ok = busy_ok && !bus.busy;
            break;
         end
         busy_ok = busy_ok && bus.busy;
      end
      res = bus.result;
      exc = bus.exception;
   endtask

   // Start mult 3*4, then start a divide whose start edge is k edges later.
   task automatic restart_seq(input string name, input int k, input logic [N-1:0] a2,
                              input logic [N-1:0] b2, input logic [N-1:0] exp_res);
      int           n_rdy;
      int           at;
      logic [N-1:0] r;
      logic         cleared;
      n_rdy   = 0;
      at      = -1;
      r       = '0;
      cleared = 1'b0;
      @(negedge clk);
      bus.ctrl_mult = 1'b1;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd4;
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      for (int j = 1; j <= k + LAT + 8; j++) begin
         if (j == k) begin
            bus.ctrl_div  = 1'b1;
            bus.operand_a = a2;
            bus.operand_b = b2;
         end
         @(posedge clk);
         #1;
         if (j == k) begin
            bus.ctrl_div  = 1'b0;
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            cleared       = (bus.result == '0) && bus.busy;
         end
         if (bus.result_rdy) begin
            n_rdy++;
            at = j;
            r  = bus.result;
         end
      end
      check({name, "_strobes"}, n_rdy, 1);
      check({name, "_edge"}, at, k + LAT);
      check({name, "_res"}, r, exp_res);
      check({name, "_restart"}, cleared, 1'b1);
   endtask

   initial begin
      vec_t         vecs [12];
      int           lat;
      int           n_rdy;
      logic [N-1:0] res;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] exp_res;
      logic         exc;
      logic         exp_exc;
      logic         busy_ok;
      logic         clr_ok;
      logic         m;

      vecs[0]  = '{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 32'd6,         32'd3,         32'd18,        1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'd100,       32'd7,         32'd14,        1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'd0,         32'hFFFF_FFFB, 32'h0000_0000, 1'b0};

      clr_n         = 1'b0;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", bus.result, '0);
      check("reset_rdy", bus.result_rdy, 1'b0);
      check("reset_exc", bus.exception, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      @(negedge clk);
      clr_n = 1'b1;

      // Directed table; successive entries also exercise back-to-back starts.
      foreach (vecs[i]) begin
         run_op(vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b, lat, res, exc, busy_ok, clr_ok);
         check($sformatf("vec%0d_lat", i), lat, LAT);
         check($sformatf("vec%0d_res", i), res, vecs[i].res);
         check($sformatf("vec%0d_exc", i), exc, vecs[i].exc);
         check($sformatf("vec%0d_busy", i), busy_ok, 1'b1);
         check($sformatf("vec%0d_clear", i), clr_ok, 1'b1);
      end

      // The strobe lasts one cycle and the result holds afterwards.
      run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, res, exc, busy_ok, clr_ok);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold_rdy", bus.result_rdy, 1'b0);
         check("hold_res", bus.result, 32'hFFFF_FFEB);
         check("hold_busy", bus.busy, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         m = 1'($urandom_range(0, 1));
         a = rand_operand();
         b = rand_operand();
         model(m, a, b, exp_res, exp_exc);
         run_op(m, !m, a, b, lat, res, exc, busy_ok, clr_ok);
         check($sformatf("rnd%0d_lat", i), lat, LAT);
         check($sformatf("rnd%0d_res(%s %0h %0h)", i, m ? "mul" : "div", a, b), res, exp_res);
         check($sformatf("rnd%0d_exc", i), exc, exp_exc);
      end

      restart_seq("restart_run", 10, 32'd100, 32'd7, 32'd14);
      restart_seq("restart_done", LAT, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);

      // Reset during the ready cycle clears the outputs without a clock edge.
      run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, lat, res, exc, busy_ok, clr_ok);
      check("prerst_rdy", bus.result_rdy, 1'b1);
      #1;
      clr_n = 1'b0;
      #1;
      check("rst_rdy_result", bus.result, '0);
      check("rst_rdy_strobe", bus.result_rdy, 1'b0);
      check("rst_rdy_exc", bus.exception, 1'b0);
      @(negedge clk);
      clr_n = 1'b1;

      // Reset at cycle 20 of an operation: no result ever follows.
      @(negedge clk);
      bus.ctrl_div  = 1'b1;
      bus.operand_a = 32'd1000;
      bus.operand_b = 32'd3;
      @(posedge clk);
      #1;
      bus.ctrl_div = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_busy_before", bus.busy, 1'b1);
      #1;
      clr_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_rdy", bus.result_rdy, 1'b0);
      check("midrst_result", bus.result, '0);
      @(negedge clk);
      clr_n = 1'b1;
      n_rdy = 0;
      for (int j = 0; j < LAT + 10; j++) begin
         @(posedge clk);
         #1;
         if (bus.result_rdy) n_rdy++;
      end
      check("midrst_no_strobe", n_rdy, 0);

      run_op(1'b1, 1'b1, 32'd6, 32'd3, lat, res, exc, busy_ok, clr_ok);
      check("post_rst_lat", lat, LAT);
      check("post_rst_res", res, 32'd18);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
